// File: rtl/simd_pipe_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : simd_pipe_alu_pkg
//  Purpose : Shared definitions for the packed-integer SIMD execute unit.
//            Holds the opcode encodings, the lane-size encodings, a helper
//            that turns a lane-size code into a byte count, and the
//            elaboration-time DATA_W check macro.
//  Options : SIMD_SAT_EN enables the saturating ops PADDS and PADDUS.
//  Revision: 1.0  initial release
// ============================================================================

// Elaboration check: the datapath is built from 64-bit slices, so the width
// must be a non-zero multiple of 64.
`define SIMD_DATA_W_CHECK(W) \
    if ((((W) % 64) != 0) || ((W) < 64)) begin : g_bad_data_w \
        $error("simd_pipe_alu: DATA_W must be a non-zero multiple of 64"); \
    end

package simd_pipe_alu_pkg;

    // Operation codes
    localparam logic [3:0] SIMD_OP_PADD   = 4'b0000;
    localparam logic [3:0] SIMD_OP_PSUB   = 4'b0001;
    localparam logic [3:0] SIMD_OP_PMAXS  = 4'b0010;
    localparam logic [3:0] SIMD_OP_PMINS  = 4'b0011;
    localparam logic [3:0] SIMD_OP_MOVQ   = 4'b0100;
    localparam logic [3:0] SIMD_OP_PCMPEQ = 4'b0101;
    localparam logic [3:0] SIMD_OP_PCMPGT = 4'b0110;
    localparam logic [3:0] SIMD_OP_PAND   = 4'b0111;
    localparam logic [3:0] SIMD_OP_POR    = 4'b1000;
    localparam logic [3:0] SIMD_OP_PXOR   = 4'b1001;
    localparam logic [3:0] SIMD_OP_PADDS  = 4'b1010;
    localparam logic [3:0] SIMD_OP_PADDUS = 4'b1011;

    // Lane-size encodings
    localparam logic [1:0] SIMD_ESZ_8  = 2'b00;
    localparam logic [1:0] SIMD_ESZ_16 = 2'b01;
    localparam logic [1:0] SIMD_ESZ_32 = 2'b10;
    localparam logic [1:0] SIMD_ESZ_64 = 2'b11;

    // Number of bytes in one lane for a given lane-size code (1/2/4/8).
    function automatic int lane_bytes(input logic [1:0] esz);
        return 1 << esz;
    endfunction

endpackage

`default_nettype wire

// File: rtl/simd_lane_alu.sv
`default_nettype none
// ============================================================================
//  Module  : simd_lane_alu
//  Purpose : Combinational 64-bit SIMD slice. Byte-granular carry chains are
//            restarted at every lane boundary so carries never cross lanes;
//            compare and saturation flags are taken from the top byte of
//            each lane and broadcast back across that lane.
//  Ports   : i_op   operation code
//            i_esz  lane size (00=8b, 01=16b, 10=32b, 11=64b)
//            i_dst  destination operand slice
//            i_src  source operand slice
//            o_res  result slice
//            o_sat  any lane clamped (present only with SIMD_SAT_EN)
//  Options : SIMD_SAT_EN enables PADDS/PADDUS and the o_sat port.
//  Revision: 1.0  initial release
// ============================================================================
module simd_lane_alu
    import simd_pipe_alu_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [1:0]  i_esz,
    input  logic [63:0] i_dst,
    input  logic [63:0] i_src,
`ifdef SIMD_SAT_EN
    output logic        o_sat,
`endif
    output logic [63:0] o_res
);

    logic [63:0] w_sum;    // dst + src, segmented
    logic [63:0] w_dif;    // dst - src, segmented
    logic [7:0]  w_vsub;   // signed overflow of the subtract at each byte
    logic [7:0]  w_top;    // byte is the most significant byte of its lane
    logic [7:0]  w_eq;     // per lane: dst == src
    logic [7:0]  w_lt;     // per lane: signed dst < src
`ifdef SIMD_SAT_EN
    logic [7:0]  w_vadd;   // signed overflow of the add at each byte
    logic [7:0]  w_cadd;   // unsigned carry out of the add at each byte
    logic [7:0]  w_ovs;    // per lane: signed add overflowed
    logic [7:0]  w_ovu;    // per lane: unsigned add overflowed
    logic [7:0]  w_pos;    // per lane: dst is non-negative (clamp direction)
`endif

    // Segmented add and subtract. Subtract is dst + ~src + 1 with the +1
    // injected at the bottom byte of every lane.
    always_comb begin
        logic [8:0] w_a;
        logic [8:0] w_s;
        logic       w_ca;
        logic       w_cs;
        w_sum  = '0;
        w_dif  = '0;
        w_vsub = '0;
        w_top  = '0;
`ifdef SIMD_SAT_EN
        w_vadd = '0;
        w_cadd = '0;
`endif
        w_a    = '0;
        w_s    = '0;
        w_ca   = 1'b0;
        w_cs   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if ((i % lane_bytes(i_esz)) == 0) begin
                w_ca = 1'b0;
                w_cs = 1'b1;
            end
            w_top[i] = (((i + 1) % lane_bytes(i_esz)) == 0);
            w_a = {1'b0, i_dst[8*i +: 8]} + {1'b0, i_src[8*i +: 8]} + {8'd0, w_ca};
            w_s = {1'b0, i_dst[8*i +: 8]} + {1'b0, ~i_src[8*i +: 8]} + {8'd0, w_cs};
            w_sum[8*i +: 8] = w_a[7:0];
            w_dif[8*i +: 8] = w_s[7:0];
            // Carry into bit 7 is recovered from the sum bit; xor with the
            // carry out gives signed overflow.
            w_vsub[i] = (w_s[7] ^ i_dst[8*i+7] ^ ~i_src[8*i+7]) ^ w_s[8];
`ifdef SIMD_SAT_EN
            w_vadd[i] = (w_a[7] ^ i_dst[8*i+7] ^ i_src[8*i+7]) ^ w_a[8];
            w_cadd[i] = w_a[8];
`endif
            w_ca = w_a[8];
            w_cs = w_s[8];
        end
    end

    // Per-lane flags, indexed by lane number.
    always_comb begin
        logic [2:0] w_ln;
        w_eq = '1;
        w_lt = '0;
`ifdef SIMD_SAT_EN
        w_ovs = '0;
        w_ovu = '0;
        w_pos = '0;
`endif
        w_ln = '0;
        for (int i = 0; i < 8; i++) begin
            w_ln = 3'(i / lane_bytes(i_esz));
            if (w_dif[8*i +: 8] != 8'd0) begin
                w_eq[w_ln] = 1'b0;
            end
            if (w_top[i]) begin
                // signed less-than = N xor V of dst - src
                w_lt[w_ln]  = w_dif[8*i+7] ^ w_vsub[i];
`ifdef SIMD_SAT_EN
                w_ovs[w_ln] = w_vadd[i];
                w_ovu[w_ln] = w_cadd[i];
                w_pos[w_ln] = ~i_dst[8*i+7];
`endif
            end
        end
    end

    // Result select, byte by byte, using the flags of the owning lane.
    always_comb begin
        logic [2:0] w_ln;
        logic       w_gt;
        logic [7:0] w_db;
        logic [7:0] w_sb;
        o_res = '0;
`ifdef SIMD_SAT_EN
        o_sat = 1'b0;
`endif
        w_ln = '0;
        w_gt = 1'b0;
        w_db = '0;
        w_sb = '0;
        for (int i = 0; i < 8; i++) begin
            w_ln = 3'(i / lane_bytes(i_esz));
            w_gt = ~w_lt[w_ln] & ~w_eq[w_ln];
            w_db = i_dst[8*i +: 8];
            w_sb = i_src[8*i +: 8];
            case (i_op)
                SIMD_OP_PADD:   o_res[8*i +: 8] = w_sum[8*i +: 8];
                SIMD_OP_PSUB:   o_res[8*i +: 8] = w_dif[8*i +: 8];
                // equal lanes return dst for both max and min
                SIMD_OP_PMAXS:  o_res[8*i +: 8] = w_lt[w_ln] ? w_sb : w_db;
                SIMD_OP_PMINS:  o_res[8*i +: 8] = w_gt ? w_sb : w_db;
                SIMD_OP_MOVQ:   o_res[8*i +: 8] = w_sb;
                SIMD_OP_PCMPEQ: o_res[8*i +: 8] = {8{w_eq[w_ln]}};
                SIMD_OP_PCMPGT: o_res[8*i +: 8] = {8{w_gt}};
                SIMD_OP_PAND:   o_res[8*i +: 8] = w_db & w_sb;
                SIMD_OP_POR:    o_res[8*i +: 8] = w_db | w_sb;
                SIMD_OP_PXOR:   o_res[8*i +: 8] = w_db ^ w_sb;
`ifdef SIMD_SAT_EN
                SIMD_OP_PADDS: begin
                    if (w_ovs[w_ln]) begin
                        // clamp: top byte 7F/80, lower bytes FF/00
                        if (w_top[i]) begin
                            o_res[8*i +: 8] = w_pos[w_ln] ? 8'h7F : 8'h80;
                        end else begin
                            o_res[8*i +: 8] = w_pos[w_ln] ? 8'hFF : 8'h00;
                        end
                        o_sat = 1'b1;
                    end else begin
                        o_res[8*i +: 8] = w_sum[8*i +: 8];
                    end
                end
                SIMD_OP_PADDUS: begin
                    if (w_ovu[w_ln]) begin
                        o_res[8*i +: 8] = 8'hFF;
                        o_sat = 1'b1;
                    end else begin
                        o_res[8*i +: 8] = w_sum[8*i +: 8];
                    end
                end
`endif
                default:        o_res[8*i +: 8] = 8'h00;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/simd_pipe_alu.sv
`default_nettype none
// ============================================================================
//  Module  : simd_pipe_alu
//  Purpose : Two-stage pipelined packed-integer SIMD execute unit with
//            valid/ready handshakes on both sides and a pass-through tag.
//            S1 registers the op and operands; S2 registers the result.
//  Ports   : clk, rst_n (async active-low), flush (sync kill of in-flight ops)
//            in_valid/in_ready/in_op/in_esz/in_dst/in_src/in_tag  op input
//            out_valid/out_ready/out_data/out_tag/out_sat         writeback
//  Params  : DATA_W operand width (multiple of 64), TAG_W tag width
//  Options : SIMD_SAT_EN enables PADDS/PADDUS and a registered out_sat;
//            without it out_sat is tied 0.
//  Revision: 1.0  initial release
// ============================================================================
module simd_pipe_alu
    import simd_pipe_alu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [1:0]        in_esz,
    input  logic [DATA_W-1:0] in_dst,
    input  logic [DATA_W-1:0] in_src,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_sat
);

    `SIMD_DATA_W_CHECK(DATA_W)

    localparam int SLICES = DATA_W / 64;

    // Stage 1: operand register
    logic              r_s1_valid;
    logic [3:0]        r_s1_op;
    logic [1:0]        r_s1_esz;
    logic [DATA_W-1:0] r_s1_dst;
    logic [DATA_W-1:0] r_s1_src;
    logic [TAG_W-1:0]  r_s1_tag;

    // Stage 2: result register
    logic              r_s2_valid;
    logic [DATA_W-1:0] r_s2_data;
    logic [TAG_W-1:0]  r_s2_tag;

    logic              w_s1_load;
    logic              w_s2_load;
    logic [DATA_W-1:0] w_res;

    // S2 advances when empty or drained; S1 advances when empty or S2 takes
    // its content. in_ready therefore depends combinationally on out_ready.
    assign w_s2_load = ~r_s2_valid | out_ready;
    assign w_s1_load = ~r_s1_valid | w_s2_load;
    assign in_ready  = w_s1_load;

    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;
    assign out_tag   = r_s2_tag;

`ifdef SIMD_SAT_EN
    logic [SLICES-1:0] w_sat_vec;
    logic              r_s2_sat;
`endif

    for (genvar k = 0; k < SLICES; k++) begin : g_slice
        simd_lane_alu u_lane (
            .i_op  (r_s1_op),
            .i_esz (r_s1_esz),
            .i_dst (r_s1_dst[64*k +: 64]),
            .i_src (r_s1_src[64*k +: 64]),
`ifdef SIMD_SAT_EN
            .o_sat (w_sat_vec[k]),
`endif
            .o_res (w_res[64*k +: 64])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_esz   <= '0;
            r_s1_dst   <= '0;
            r_s1_src   <= '0;
            r_s1_tag   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_tag   <= '0;
        end else begin
            // An op accepted in a flush cycle is dropped along with the rest.
            if (flush) begin
                r_s1_valid <= 1'b0;
                r_s2_valid <= 1'b0;
            end else begin
                if (w_s2_load) begin
                    r_s2_valid <= r_s1_valid;
                end
                if (w_s1_load) begin
                    r_s1_valid <= in_valid;
                end
            end
            // Payloads only move with a valid op so held outputs stay stable.
            if (w_s2_load && r_s1_valid) begin
                r_s2_data <= w_res;
                r_s2_tag  <= r_s1_tag;
            end
            if (w_s1_load && in_valid) begin
                r_s1_op  <= in_op;
                r_s1_esz <= in_esz;
                r_s1_dst <= in_dst;
                r_s1_src <= in_src;
                r_s1_tag <= in_tag;
            end
        end
    end

`ifdef SIMD_SAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_sat <= 1'b0;
        end else if (w_s2_load && r_s1_valid) begin
            r_s2_sat <= |w_sat_vec;
        end
    end
    assign out_sat = r_s2_sat;
`else
    assign out_sat = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/simd_pipe_alu.md
Name: simd_pipe_alu

Overview:
- Next-generation packed-integer MMX execute unit: parametrised datapath width, run-time lane size (8/16/32/64), extended op set.
- Two-stage pipeline with valid/ready handshakes on both sides, plus a pass-through tag for writeback.
- Sits in the execute stage beside the integer ALU; consumes decoded MMX ops and drives the MM register writeback bus.

Parameters:
- DATA_W, 64, operand/result width; must be a multiple of 64.
- TAG_W, 4, width of the opaque tag (dest MM reg id plus spare) carried alongside the op.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all in-flight ops.
- in_valid  in  1  op presented.
- in_ready  out  1  unit can accept the op this cycle.
- in_op  in  4  operation code (see Behaviour).
- in_esz  in  2  lane size: 00=8b, 01=16b, 10=32b, 11=64b.
- in_dst  in  DATA_W  destination operand (mm).
- in_src  in  DATA_W  source operand (mm/m64).
- in_tag  in  TAG_W  opaque tag.
- out_valid  out  1  result available.
- out_ready  in  1  writeback accepts the result.
- out_data  out  DATA_W  result.
- out_tag  out  TAG_W  tag of the result.
- out_sat  out  1  at least one lane saturated; 0 when SIMD_SAT_EN is undefined.

Behaviour:
- Ops are lane-wise over DATA_W/lane bits. Unused codes produce out_data=0 and still complete normally.
  - 0000 PADD: wrap modulo 2^lane.
  - 0001 PSUB: dst-src, wrap.
  - 0010 PMAXS: signed max.
  - 0011 PMINS: signed min.
  - 0100 MOVQ: out=src; lane size ignored.
  - 0101 PCMPEQ: lane all-ones if equal, else zero.
  - 0110 PCMPGT: signed dst>src gives all-ones.
  - 0111 PAND, 1000 POR, 1001 PXOR: bitwise; lane size ignored.
  - 1010 PADDS: signed saturating add.
  - 1011 PADDUS: unsigned saturating add.
- Carries never cross lane boundaries. PMAXS/PMINS with equal lanes return dst.
- Pipeline: S1 is an input register (op, esz, operands, tag). S2 holds the computed result and tag. Latency 2 cycles from in_valid&&in_ready to out_valid, with no bubbles in steady state.
- Handshake:
  - Transfer on valid&&ready. A producer must hold in_* stable while in_valid && !in_ready.
  - out_data and out_tag stay stable while out_valid && !out_ready.
  - S2 loads when it is empty or out_ready=1. S1 loads when it is empty or S2 loads.
  - in_ready = !s1_valid || s2_load. This is a combinational path from out_ready; full throughput at 1 op/clk.
- Backpressure: with out_ready=0 the unit holds exactly 2 ops, then in_ready=0. On release, ops drain in order with no loss or duplication.
- flush: both stage valids clear at the next edge. in_ready is still computed normally; an op accepted in the flush cycle is discarded.
- Reset: rst_n low clears s1_valid, s2_valid, out_valid, out_data, out_tag and out_sat to 0 immediately (asynchronously). in_ready=1 after reset. Reset mid-operation drops all in-flight ops.

Optional Feature:
- Macro: SIMD_SAT_EN.
- Defined: ops 1010/1011 are implemented. Each lane clamps to signed max/min (PADDS) or to 2^lane-1 (PADDUS). out_sat is registered with the result and is 1 if any lane clamped.
- Undefined: 1010/1011 decode as unused (out_data=0); out_sat is tied 0.

Decomposition:
- Shared package / include: opcode localparams (SIMD_OP_PADD...SIMD_OP_PADDUS), lane-size encodings, the DATA_W%64 check macro.
- One sub-module: simd_lane_alu, the combinational 64-bit slice with lane-size-segmented carry chain, compare and saturate. It is instantiated DATA_W/64 times in S2's input logic. Pipeline control stays in the top.

Test Plan:
- PADD esz=01, dst=0x7FFF_0001_FFFF_8000, src=0x0001_0001_0001_8000 -> out_data=0x8000_0002_0000_0000, out_valid 2 cycles after accept, tag echoed.
- PMINS esz=00, dst=0x80_7F_00_FF_..., src=0x7F_80_01_00_... -> lanes 0x80,0x80,0x00,0xFF; PMAXS on the same operands -> 0x7F,0x7F,0x01,0x00.
- SIMD_SAT_EN: PADDS esz=01, dst=0x7FFF_8000_0001_0000, src=0x0001_FFFF_0001_0000 -> 0x7FFF_8000_0002_0000, out_sat=1. PADDUS esz=00, 0xF0+0x20 -> 0xFF.
- Back-to-back 8 ops with tags 0..7, out_ready low for cycles 3-6 -> in_ready drops after 2 held ops; outputs in tag order 0..7, each exactly once, data stable while stalled.
- Two ops in flight, flush asserted 1 cycle -> out_valid=0 next cycle, neither tag ever appears; the next op completes normally.
- rst_n pulsed low mid-stall -> all outputs 0 immediately; after release in_ready=1 and the first new op returns in 2 cycles.
